// File: rtl/edge_count_engine_pkg.sv
// Shared types and derived constants for edge_count_engine and fir5_mac.
package edge_count_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Filter taps per window.
  localparam int unsigned N_TAPS = 5;

  // Reads issued before the first complete window (p-2 .. p+1).
  localparam int unsigned PRIME_READS = 4;

  // Valid stages inside fir5_mac after the window register:
  // window -> products -> sum (compare is combinational on the sum).
  localparam int unsigned PIPE_DEPTH = 3;

  // Signed sum width: product width plus growth for five terms.
  function automatic int unsigned sum_w(input int unsigned pix_w, input int unsigned coef_w);
    return pix_w + coef_w + 3;
  endfunction

  // First evaluated pixel: start of the second row.
  function automatic int unsigned p_first(input int unsigned img_w);
    return img_w;
  endfunction

  // Last evaluated pixel: end of the second-to-last row.
  function automatic int unsigned p_last(input int unsigned img_w, input int unsigned img_h);
    return img_w * (img_h - 1) - 1;
  endfunction

endpackage

// File: rtl/edge_count_engine_fir5_mac.sv
// fir5_mac: 5-pixel window shift register, signed products, adder tree and
// magnitude compare. Window data enters on shift_en; eval marks the shifts
// that complete a window to be evaluated.
module fir5_mac
  import edge_count_pkg::*;
#(
  parameter  int unsigned PIX_W  = 8,
  parameter  int unsigned COEF_W = 4,
  localparam int unsigned SUM_W  = sum_w(PIX_W, COEF_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     shift_en,
  input  logic                     eval,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic [N_TAPS*COEF_W-1:0] coef,
  input  logic [SUM_W-1:0]         thresh,
  output logic                     pending,
  output logic                     out_valid,
  output logic                     out_hit
);

  localparam int unsigned PROD_W = PIX_W + COEF_W;

  logic [PIX_W-1:0]         win    [N_TAPS];
  logic signed [PROD_W-1:0] prod_d [N_TAPS];
  logic signed [PROD_W-1:0] prod_q [N_TAPS];
  logic signed [SUM_W-1:0]  pair01, pair23, sum_d, sum_q;
  logic [SUM_W-1:0]         mag;
  logic [PIPE_DEPTH-1:0]    vld_q;

  // Window shift register: win[0] is pixel p-2, win[4] is pixel p+2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_TAPS; i++) win[i] <= '0;
    end else if (shift_en) begin
      for (int unsigned i = 0; i < N_TAPS - 1; i++) win[i] <= win[i+1];
      win[N_TAPS-1] <= pix_in;
    end
  end

  // Valid tags travelling alongside the data; flush drops everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[PIPE_DEPTH-2:0], shift_en & eval};
    end
  end

  // Stage 1 products: pixel zero-extended, coefficient sign-extended.
  always_comb begin
    for (int unsigned k = 0; k < N_TAPS; k++) begin
      prod_d[k] = PROD_W'($signed({1'b0, win[k]})) *
                  PROD_W'($signed(coef[k*COEF_W +: COEF_W]));
    end
  end

  // Stage 1 product registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < N_TAPS; k++) prod_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_TAPS; k++) prod_q[k] <= prod_d[k];
    end
  end

  // Stage 2 adder tree; SUM_W leaves headroom so no overflow is possible.
  always_comb begin
    pair01 = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]);
    pair23 = SUM_W'(prod_q[2]) + SUM_W'(prod_q[3]);
    sum_d  = pair01 + pair23 + SUM_W'(prod_q[4]);
  end

  // Stage 2 sum register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  // Stage 3 magnitude and strict compare against the threshold.
  always_comb begin
    mag       = sum_q[SUM_W-1] ? $unsigned(-sum_q) : $unsigned(sum_q);
    out_hit   = (mag > thresh);
    out_valid = vld_q[PIPE_DEPTH-1];
    pending   = |vld_q[PIPE_DEPTH-2:0];
  end

endmodule

// File: rtl/edge_count_engine.sv
// edge_count_engine: scans the interior rows of an image held in a
// single-port SRAM, filters each pixel with a programmable 5-tap signed FIR
// and counts responses whose magnitude strictly exceeds a threshold.
// Optional macro EDGE_MAP_OUT_EN adds the per-pixel edge_valid/edge_flag
// stream in scan order.
module edge_count_engine
  import edge_count_pkg::*;
#(
  parameter  int unsigned IMG_W  = 160,
  parameter  int unsigned IMG_H  = 90,
  parameter  int unsigned PIX_W  = 8,
  parameter  int unsigned ADDR_W = 14,
  parameter  int unsigned CNT_W  = 16,
  parameter  int unsigned COEF_W = 4,
  localparam int unsigned SUM_W  = sum_w(PIX_W, COEF_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N_TAPS*COEF_W-1:0] coef,
  input  logic [SUM_W-1:0]         thresh,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [PIX_W-1:0]         mem_data,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         edge_count
`ifdef EDGE_MAP_OUT_EN
  ,
  output logic                     edge_valid,
  output logic                     edge_flag
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_FIRST      = ADDR_W'(p_first(IMG_W) - 2);
  localparam logic [ADDR_W-1:0] ADDR_PRIME_LAST = ADDR_W'(p_first(IMG_W) - 2 + PRIME_READS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST       = ADDR_W'(p_last(IMG_W, IMG_H) + 2);

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q;
  logic [N_TAPS*COEF_W-1:0]   coef_q;
  logic [SUM_W-1:0]           thresh_q;
  logic                       rd_vld_q, rd_run_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       accept;
  logic                       pending, out_valid, out_hit;

  assign accept     = (state_q == IDLE) && start && !abort;
  assign mem_addr   = addr_q;
  assign edge_count = cnt_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs. Abort overrides every transition.
  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_d = PRIME;
      end
      PRIME: begin
        mem_en = 1'b1;
        if (addr_q == ADDR_PRIME_LAST) state_d = RUN;
      end
      RUN: begin
        mem_en = 1'b1;
        if (addr_q == ADDR_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave once only the final stage still holds data; it retires
        // on the same edge that enters DONE.
        if (!rd_vld_q && !pending) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Read address: loaded on start, advances with every issued read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      addr_q <= '0;
    else if (accept) addr_q <= ADDR_FIRST;
    else if (mem_en) addr_q <= addr_q + ADDR_W'(1);
  end

  // Coefficients and threshold are frozen for the whole scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coef_q   <= '0;
      thresh_q <= '0;
    end else if (accept) begin
      coef_q   <= coef;
      thresh_q <= thresh;
    end
  end

  // Tracks which cycles carry returning SRAM data and whether it completes a window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_q <= 1'b0;
      rd_run_q <= 1'b0;
    end else if (abort) begin
      rd_vld_q <= 1'b0;
      rd_run_q <= 1'b0;
    end else begin
      rd_vld_q <= mem_en;
      rd_run_q <= (state_q == RUN);
    end
  end

  fir5_mac #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .shift_en  (rd_vld_q),
    .eval      (rd_run_q),
    .pix_in    (mem_data),
    .coef      (coef_q),
    .thresh    (thresh_q),
    .pending   (pending),
    .out_valid (out_valid),
    .out_hit   (out_hit)
  );

  // Saturating edge counter, cleared on start, frozen on abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (out_valid && out_hit && !abort && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef EDGE_MAP_OUT_EN
  // Per-pixel result stream, aligned with the counter update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_valid <= 1'b0;
      edge_flag  <= 1'b0;
    end else begin
      edge_valid <= out_valid && !abort;
      edge_flag  <= out_valid && out_hit && !abort;
    end
  end
`endif

endmodule

// File: tb/tb_edge_count_engine.sv
// Self-checking bench for edge_count_engine: a 160x90 instance and a small
// 12x4 instance with a 4-bit counter, each with its own SRAM model.
module tb_edge_count_engine;

  localparam int AW = 160, AH = 90, NA = AW * (AH - 2);
  localparam int BW = 12,  BH = 4,  NB = BW * (BH - 2);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] coef = '0;
  logic [14:0] thresh = '0;
  logic startA = 1'b0, abortA = 1'b0, startB = 1'b0, abortB = 1'b0;

  logic        enA, busyA, doneA;
  logic [13:0] addrA;
  logic [7:0]  dataA = '0;
  logic [15:0] cntA;
  logic        enB, busyB, doneB;
  logic [5:0]  addrB;
  logic [7:0]  dataB = '0;
  logic [3:0]  cntB;
  logic        evA, evB, flA, flB;

  logic [7:0] imgA [AW*AH];
  logic [7:0] imgB [BW*BH];

  edge_count_engine #(
    .IMG_W(AW), .IMG_H(AH), .PIX_W(8), .ADDR_W(14), .CNT_W(16), .COEF_W(4)
  ) dut_a (
    .clk(clk), .reset(reset), .start(startA), .abort(abortA),
    .coef(coef), .thresh(thresh), .mem_en(enA), .mem_addr(addrA),
    .mem_data(dataA), .busy(busyA), .done(doneA), .edge_count(cntA)
`ifdef EDGE_MAP_OUT_EN
    , .edge_valid(evA), .edge_flag(flA)
`endif
  );

  edge_count_engine #(
    .IMG_W(BW), .IMG_H(BH), .PIX_W(8), .ADDR_W(6), .CNT_W(4), .COEF_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .start(startB), .abort(abortB),
    .coef(coef), .thresh(thresh), .mem_en(enB), .mem_addr(addrB),
    .mem_data(dataB), .busy(busyB), .done(doneB), .edge_count(cntB)
`ifdef EDGE_MAP_OUT_EN
    , .edge_valid(evB), .edge_flag(flB)
`endif
  );

`ifndef EDGE_MAP_OUT_EN
  assign evA = 1'b0; assign evB = 1'b0; assign flA = 1'b0; assign flB = 1'b0;
`endif

  // Synchronous SRAMs, one-cycle read latency.
  always @(posedge clk) begin
    if (enA) dataA <= imgA[addrA];
    if (enB) dataB <= imgB[addrB];
  end

  bit sel = 1'b0;
  logic done_m, busy_m, ev_m, fl_m;
  logic [15:0] cnt_m;
  assign done_m = sel ? doneB : doneA;
  assign busy_m = sel ? busyB : busyA;
  assign ev_m   = sel ? evB : evA;
  assign fl_m   = sel ? flB : flA;
  assign cnt_m  = sel ? {12'd0, cntB} : cntA;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive_start(input bit s, input logic v);
    if (s) startB = v; else startA = v;
  endtask

  // Reference: direct evaluation of every interior window from the image.
  function automatic int model(input bit s, input logic [19:0] cf, input int th);
    int w, h, cmax, cnt;
    w = s ? BW : AW; h = s ? BH : AH; cmax = s ? 15 : 65535; cnt = 0;
    for (int p = w; p <= w * (h - 1) - 1; p++) begin
      int sum;
      sum = 0;
      for (int k = 0; k < 5; k++) begin
        int c, px;
        c = int'(cf[4*k +: 4]);
        if (c > 7) c -= 16;
        px = s ? int'(imgB[p-2+k]) : int'(imgA[p-2+k]);
        sum += c * px;
      end
      if (sum < 0) sum = -sum;
      if (sum > th && cnt < cmax) cnt++;
    end
    return cnt;
  endfunction

  task automatic fill_b(input logic [7:0] v);
    for (int i = 0; i < BW*BH; i++) imgB[i] = v;
  endtask

  task automatic fill_step_a();
    for (int y = 0; y < AH; y++)
      for (int x = 0; x < AW; x++) imgA[y*AW+x] = (x < 80) ? 8'd0 : 8'd255;
  endtask

  // One scan; k counts negedges after the start-sampling edge.
  task automatic run_scan(input bit s, input int restart_at, output int done_k,
                          output int pulses, output int ev_n, output int fl_n,
                          output int busy_err, output int cnt);
    int n, limit;
    n = s ? NB : NA; limit = n + 9 + 40;
    done_k = -1; pulses = 0; ev_n = 0; fl_n = 0; busy_err = 0;
    sel = s;
    @(negedge clk); drive_start(s, 1'b1);
    @(negedge clk); drive_start(s, 1'b0);
    for (int k = 1; k <= limit; k++) begin
      drive_start(s, k == restart_at);
      if (done_m) begin pulses++; if (done_k < 0) done_k = k; end
      if (ev_m) ev_n++;
      if (fl_m) fl_n++;
      if (busy_m != (k <= n + 9)) busy_err++;
      @(negedge clk);
    end
    cnt = int'(cnt_m);
  endtask

  typedef struct {
    logic [7:0]  fill;
    logic [19:0] cf;
    int          th;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int dk, pl, ev, fl, be, cnt, exp_c;
    logic [19:0] rc;
    int rt;

    vecs[0] = '{8'd10,  20'h00001, 9,     15};
    vecs[1] = '{8'd10,  20'h00001, 10,    0};
    vecs[2] = '{8'd100, 20'h120EF, 0,     0};
    vecs[3] = '{8'd255, 20'h00007, 1784,  15};
    vecs[4] = '{8'd255, 20'h00007, 1785,  0};
    vecs[5] = '{8'd255, 20'h88888, 10199, 15};
    vecs[6] = '{8'd255, 20'h88888, 10200, 0};
    vecs[7] = '{8'd3,   20'h11111, 14,    15};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", busyA, 0);
    check("rst_done", doneA, 0);
    check("rst_mem_en", enA, 0);
    check("rst_mem_addr", addrA, 0);
    check("rst_count", cntA, 0);
    reset = 1'b1;
    @(negedge clk);

    // All-zero image on 160x90.
    for (int i = 0; i < AW*AH; i++) imgA[i] = 8'd0;
    coef = 20'h120EF; thresh = 15'd200;
    run_scan(1'b0, 0, dk, pl, ev, fl, be, cnt);
    check("zero_done_cycle", dk, NA + 9);
    check("zero_done_pulses", pl, 1);
    check("zero_busy_window", be, 0);
    check("zero_count", cnt, 0);
`ifdef EDGE_MAP_OUT_EN
    check("zero_edge_valid_n", ev, NA);
`endif

    // Step image: 8 hits per interior row (4 at x=80, 4 across row wrap).
    fill_step_a();
    run_scan(1'b0, 0, dk, pl, ev, fl, be, cnt);
    check("step_done_cycle", dk, NA + 9);
    check("step_count", cnt, 704);
`ifdef EDGE_MAP_OUT_EN
    check("step_edge_valid_n", ev, NA);
    check("step_edge_flag_n", fl, 704);
`endif

    // Same scan with a second start at cycle 50: ignored.
    run_scan(1'b0, 50, dk, pl, ev, fl, be, cnt);
    check("restart_done_cycle", dk, NA + 9);
    check("restart_done_pulses", pl, 1);
    check("restart_busy_window", be, 0);
    check("restart_count", cnt, 704);

    // Table of uniform images on the small instance (count saturates at 15).
    for (int v = 0; v < 8; v++) begin
      fill_b(vecs[v].fill);
      coef = vecs[v].cf; thresh = 15'(vecs[v].th);
      run_scan(1'b1, 0, dk, pl, ev, fl, be, cnt);
      check($sformatf("vec%0d_done_cycle", v), dk, NB + 9);
      check($sformatf("vec%0d_count", v), cnt, vecs[v].exp_cnt);
    end

    // Crafted windows: sums +200, -200, +201, -201 with threshold 200.
    fill_b(8'd0);
    imgB[20] = 8'd200; imgB[28] = 8'd201;
    coef = 20'hF0001; thresh = 15'd200;
    run_scan(1'b1, 0, dk, pl, ev, fl, be, cnt);
    check("crafted_count", cnt, 2);
`ifdef EDGE_MAP_OUT_EN
    check("crafted_edge_valid_n", ev, NB);
`endif

    // Randomized scans against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < BW*BH; i++) imgB[i] = 8'($urandom_range(0, 255));
      rc = 20'($urandom); rt = int'($urandom_range(0, 2500));
      coef = rc; thresh = 15'(rt);
      exp_c = model(1'b1, rc, rt);
      run_scan(1'b1, 0, dk, pl, ev, fl, be, cnt);
      check($sformatf("rand_b%0d_count", r), cnt, exp_c);
      check($sformatf("rand_b%0d_busy_window", r), be, 0);
    end
    for (int i = 0; i < AW*AH; i++) imgA[i] = 8'($urandom_range(0, 255));
    rc = 20'($urandom); rt = int'($urandom_range(1000, 4000));
    coef = rc; thresh = 15'(rt);
    exp_c = model(1'b0, rc, rt);
    run_scan(1'b0, 0, dk, pl, ev, fl, be, cnt);
    check("rand_a_count", cnt, exp_c);
    check("rand_a_done_cycle", dk, NA + 9);

    // Abort at cycle 100 of a step-image scan: windows x=0..90 of row 1 counted.
    fill_step_a();
    coef = 20'h120EF; thresh = 15'd200;
    sel = 1'b0;
    @(negedge clk); startA = 1'b1;
    @(negedge clk); startA = 1'b0;
    repeat (99) @(negedge clk);
    abortA = 1'b1;
    @(negedge clk); abortA = 1'b0;
    check("abort_busy", busyA, 0);
    check("abort_mem_en", enA, 0);
    check("abort_count_hold", cntA, 6);
    pl = 0; ev = 0; be = 0;
    for (int k = 0; k < 30; k++) begin
      if (doneA) pl++;
      if (evA) ev++;
      if (cntA != 16'd6) be++;
      @(negedge clk);
    end
    check("abort_no_done", pl, 0);
    check("abort_no_edge_valid", ev, 0);
    check("abort_count_stable", be, 0);

    // Start and abort together in IDLE: stays idle.
    startA = 1'b1; abortA = 1'b1;
    @(negedge clk); startA = 1'b0; abortA = 1'b0;
    check("start_abort_busy", busyA, 0);
    check("start_abort_mem_en", enA, 0);

    // Asynchronous reset at cycle 100 of a scan.
    @(negedge clk); startA = 1'b1;
    @(negedge clk); startA = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_reset_count", cntA, 6);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", busyA, 0);
    check("midrst_count", cntA, 0);
    check("midrst_mem_en", enA, 0);
    check("midrst_mem_addr", addrA, 0);
    check("midrst_done", doneA, 0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_busy", busyA, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
